// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side consumer for the synchronous FIFO. It issues FIFO reads, absorbs
//   the FIFO's one-cycle registered read-data latency and presents words, in
//   FIFO order, on a downstream valid/ready stream. A 3-entry circular output
//   buffer sustains one word per cycle. The read request depends only on
//   registered state plus fifo_empty/enable/rst, so there is no combinational
//   path from m_ready to fifo_rd_en.
//
//   Handshake: a word moves downstream on every rising clk edge where
//   m_valid & m_ready are both high. While m_valid=1 and m_ready=0, m_data
//   holds and m_valid stays high.
//
// Parameters
//   WIDTH      data width (must match the FIFO)
//   CNT_WIDTH  width of the delivered-word counter
//
// Ports
//   clk, rst     clock (posedge) and synchronous active-high reset
//   enable       1 = issue FIFO reads; 0 = stop reading, keep draining buffer
//   fifo_rd_en   FIFO read request
//   fifo_dout    FIFO read data, valid the cycle after an accepted read
//   fifo_empty   FIFO empty flag
//   m_valid      output word valid
//   m_data       output word
//   m_ready      downstream ready
//   word_count   words delivered (only counts with the stats build)
//
// Build option
//   FIFO_STREAM_READER_STATS_EN : when defined, word_count counts pops and
//   wraps modulo 2^CNT_WIDTH; when undefined, word_count is tied to 0.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] word_count
);

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [WIDTH-1:0] ent_q [3];
    logic [2:0]       level;
    logic             push;
    logic             pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A word read from the FIFO lands in the buffer one cycle later.
    assign push = inflight_q;
    assign pop  = m_valid & m_ready;

    // Buffered words plus the word still on its way from the FIFO. Reading
    // only while this is below 3 guarantees the buffer can never overflow,
    // regardless of what m_ready does in the meantime.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q};

    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && enable && !fifo_empty && (level < 3'd3)) begin
            fifo_rd_en = 1'b1;
        end
    end

    always_comb begin
        inflight_d = fifo_rd_en & ~fifo_empty;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        head_d     = pop  ? next_idx(head_q) : head_q;
        tail_d     = push ? next_idx(tail_q) : tail_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Entries are cleared on reset so m_data reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            ent_q[2] <= '0;
        end else if (push) begin
            ent_q[tail_q] <= fifo_dout;
        end
    end

    assign m_valid = (occ_q != 2'd0);

    always_comb begin
        m_data = '0;
        case (head_q)
            2'd0:    m_data = ent_q[0];
            2'd1:    m_data = ent_q[1];
            2'd2:    m_data = ent_q[2];
            default: m_data = '0;
        endcase
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = pop ? cnt_q + CNT_ONE : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_count = cnt_q;
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Bench for fifo_stream_reader. A behavioural FIFO (queue) feeds the design;
//   every word written is also appended to exp_q, and each downstream beat must
//   match the head of exp_q. Buffer occupancy is modelled as
//   (reads accepted) - (beats delivered), which must never exceed 3 and must be
//   below 3 whenever a read is requested.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [15:0]   word_count;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .word_count (word_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural FIFO: registered dout, ignores reads while empty
  logic [W-1:0] fq[$];
  logic [W-1:0] wr_data_a [0:511];
  int           wr_tot = 0;
  int           wr_taken = 0;
  int           fifo_reads = 0;

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout  <= fq.pop_front();
      fifo_reads <= fifo_reads + 1;
    end
    while (wr_taken < wr_tot) begin
      fq.push_back(wr_data_a[wr_taken]);
      wr_taken = wr_taken + 1;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int acc = 0;
  int beats = 0;
  int cyc_no = 0;
  logic         s_rd, s_valid;
  logic [W-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [W-1:0] d);
    wr_data_a[wr_tot] = d;
    wr_tot++;
    exp_q.push_back(d);
  endtask

  // one clock cycle: sample at negedge, return just after the next posedge
  task automatic cyc();
    logic [W-1:0] e;
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    if (fifo_rd_en) chk("rd_room", 32'(acc - beats < 3), 1);
    if (fifo_rd_en && !fifo_empty) acc++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_data), 32'(e));
      end
      beats++;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 0);
    chk("idle_valid", 32'(m_valid), 0);
    chk("idle_level", 32'(acc - beats), 0);
  endtask

  function automatic logic [15:0] exp_count();
`ifdef FIFO_STREAM_READER_STATS_EN
    return 16'(beats);
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    int rd_n, v_n, rd_i, v_i, b0, a0, first_b, last_b, wn;
    logic [W-1:0] d;

    // T1: reset held while the FIFO holds 4 words
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_rd_en", 32'(s_rd), 0);
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_data", 32'(s_data), 0);
      chk("rst_fifo_reads", 32'(fifo_reads), 0);
    end
    chk("rst_count", 32'(word_count), 0);
    rst = 1'b0;
    drain();

    // T2: single word latency
    enable = 1'b1; m_ready = 1'b1;
    wr(8'hA5);
    rd_n = 0; v_n = 0; rd_i = 0; v_i = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (s_rd) begin rd_n++; rd_i = i; end
      if (s_valid) begin v_n++; v_i = i; d = s_data; end
    end
    chk("lat_rd_once", 32'(rd_n), 1);
    chk("lat_valid_once", 32'(v_n), 1);
    chk("lat_n_plus_2", 32'(v_i - rd_i), 2);
    chk("lat_data", 32'(d), 32'h A5);

    // T3: 32 preloaded words, full throughput
    enable = 1'b0;
    for (int i = 0; i < 32; i++) wr(8'(i));
    cyc(); cyc();
    enable = 1'b1; m_ready = 1'b1;
    b0 = beats; first_b = -1; last_b = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (s_valid) begin
        if (first_b < 0) first_b = i;
        last_b = i;
      end
    end
    chk("burst_beats", 32'(beats - b0), 32);
    chk("burst_no_bubble", 32'(last_b - first_b), 31);
    chk("burst_count", 32'(word_count), 32'(exp_count()));

    // T4: downstream stalled, 10 words
    enable = 1'b1; m_ready = 1'b0;
    a0 = acc; b0 = beats;
    for (int i = 0; i < 10; i++) wr(8'(i));
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i >= 6) begin
        chk("stall_valid", 32'(s_valid), 1);
        chk("stall_data", 32'(s_data), 0);
      end
    end
    chk("stall_reads", 32'(acc - a0), 3);
    drain();
    chk("stall_total", 32'(beats - b0), 10);

    // T5: enable dropped mid-stream
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 6; i++) cyc();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("dis_rd_en", 32'(s_rd), 0);
    end
    chk("dis_all_delivered", 32'(acc - beats), 0);
    chk("dis_valid", 32'(m_valid), 0);
    drain();

    // T6: slow writer, toggling m_ready
    enable = 1'b1;
    wn = 0;
    for (int i = 0; i < 400 && wn < 50; i++) begin
      if (i % 3 == 0) begin wr(8'($urandom)); wn++; end
      m_ready = i[0];
      cyc();
    end
    chk("slow_written", 32'(wn), 50);
    drain();

    // T7: random writes, ready and enable
    wn = 0;
    for (int i = 0; i < 200; i++) begin
      if (wn < 40 && $urandom_range(0, 1) == 1) begin wr(8'($urandom)); wn++; end
      m_ready = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    chk("final_count", 32'(word_count), 32'(exp_count()));
    chk("final_beats", 32'(beats), 32'(wr_tot));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
